// File: rtl/vacc_inst_dispatch.sv
// Instruction FIFO and decoder for the video accelerator: maintains the
// mover base addresses and launches routed read/write mover command pairs.
module vacc_inst_dispatch #(
    parameter int ADDR_WIDTH = 64,
    parameter int FIFO_AW    = 3,
    parameter int N_UNITS    = 3,
    parameter int DEST_WIDTH = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  inst_valid,
    input  logic [31:0]           inst_data,
    output logic                  inst_ready,
    output logic [31:0]           head_data,
    output logic [ADDR_WIDTH-1:0] rd_src,
    output logic [12:0]           rd_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] wr_dest,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DEST_WIDTH-1:0] routing_dest,
    output logic                  busy,
    output logic [31:0]           done_count,
    output logic                  err_illegal,
    input  logic                  err_clear
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PAD   = ADDR_WIDTH - 13;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_HI_RD = 3'd1;
    localparam logic [2:0] S_LD_HI_WR = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;

    logic [31:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]    wptr;
    logic [FIFO_AW-1:0]    rptr;
    logic [FIFO_AW:0]      count;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH-1:0] wr_base;

    logic [5:0]            op;
    logic [31:0]           op_w;
    logic [31:0]           base_lo;
    logic [12:0]           src_off;
    logic [12:0]           dst_off;
    logic [12:0]           len_f;
    logic                  is_main;
    logic [DEST_WIDTH-1:0] unit;

    // Count MSB is set only when the FIFO holds exactly DEPTH words.
    assign empty      = (count == '0);
    assign full       = count[FIFO_AW];
    assign inst_ready = !full;
    assign push       = inst_valid && inst_ready;
    assign head_data  = empty ? 32'd0 : mem[rptr];
    assign busy       = (state != S_IDLE) || !empty;

    assign op      = head_data[5:0];
    assign op_w    = {26'd0, op};
    assign base_lo = {head_data[31:6], 6'd0};
    assign src_off = {head_data[12:6], 6'd0};
    assign dst_off = {head_data[19:13], 6'd0};
    assign len_f   = {head_data[26:20], 6'd0};
    assign is_main = (op_w >= 32'd8) && (op_w < 32'(8 + N_UNITS));
    assign unit    = DEST_WIDTH'(op_w - 32'd8);

    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            unique case (state)
                S_IDLE, S_LD_HI_RD, S_LD_HI_WR: pop = 1'b1;
                default:                        pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wptr] <= inst_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            rd_base      <= '0;
            wr_base      <= '0;
            rd_src       <= '0;
            wr_dest      <= '0;
            rd_len       <= '0;
            routing_dest <= '0;
            rd_valid     <= 1'b0;
            wr_valid     <= 1'b0;
            done_count   <= '0;
            err_illegal  <= 1'b0;
        end else begin
            if (err_clear) err_illegal <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty && is_main) begin
                        routing_dest <= unit;
                        rd_src  <= rd_base + {{PAD{1'b0}}, src_off};
                        wr_dest <= wr_base + {{PAD{1'b0}}, dst_off};
                        rd_len  <= len_f;
                        if (len_f == '0) begin
                            done_count <= done_count + 32'd1;
                        end else begin
                            rd_valid <= 1'b1;
                            wr_valid <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end else if (!empty) begin
                        unique case (op)
                            6'd0: begin end
                            6'd2: begin
                                rd_base[31:0] <= base_lo;
                                state         <= S_LD_HI_RD;
                            end
                            6'd3: begin
                                wr_base[31:0] <= base_lo;
                                state         <= S_LD_HI_WR;
                            end
                            6'd4: rd_base[31:0] <= base_lo;
                            6'd5: wr_base[31:0] <= base_lo;
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                S_LD_HI_RD: begin
                    if (!empty) begin
                        rd_base[ADDR_WIDTH-1:32] <= head_data[ADDR_WIDTH-33:0];
                        state <= S_IDLE;
                    end
                end
                S_LD_HI_WR: begin
                    if (!empty) begin
                        wr_base[ADDR_WIDTH-1:32] <= head_data[ADDR_WIDTH-33:0];
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // Each valid drops after its own handshake.
                    if (rd_valid && rd_ready) rd_valid <= 1'b0;
                    if (wr_valid && wr_ready) wr_valid <= 1'b0;
                    if (!rd_valid && !wr_valid) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_ready && wr_ready) begin
                        done_count <= done_count + 32'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vacc_inst_dispatch.sv
// Scoreboard bench for vacc_inst_dispatch: a command-level model predicts
// mover commands, done count and error flag; a monitor checks handshakes.
module tb_vacc_inst_dispatch;

    localparam int AW = 64;
    localparam int NU = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic          inst_ready;
    logic [31:0]   head_data;
    logic [AW-1:0] rd_src;
    logic [12:0]   rd_len;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] wr_dest;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    routing_dest;
    logic          busy;
    logic [31:0]   done_count;
    logic          err_illegal;
    logic          err_clear;

    vacc_inst_dispatch #(
        .ADDR_WIDTH(AW), .FIFO_AW(3), .N_UNITS(NU), .DEST_WIDTH(3)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_ready(inst_ready), .head_data(head_data),
        .rd_src(rd_src), .rd_len(rd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_dest(wr_dest), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .routing_dest(routing_dest), .busy(busy),
        .done_count(done_count), .err_illegal(err_illegal),
        .err_clear(err_clear)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          k;
        logic [63:0] addr;
        int          len;
    } exp_t;

    exp_t        rd_q[$];
    exp_t        wr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accepted = 0;
    logic [63:0] m_rd = '0;
    logic [63:0] m_wr = '0;
    int          m_ld = 0;
    logic [31:0] exp_done = '0;
    logic        exp_err = 1'b0;
    bit          hold = 1'b0;
    int          rd_lat_sel = 0;
    int          wr_lat_sel = 0;
    bit          rd_pend = 1'b0;
    bit          wr_pend = 1'b0;
    int          rd_bcnt = 0;
    int          wr_bcnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Command-level reference: applies each accepted word in order.
    task automatic model(input logic [31:0] w);
        int          op;
        logic [31:0] lo;
        exp_t        e;
        op = int'(w[5:0]);
        lo = w & 32'hFFFF_FFC0;
        if (m_ld == 1) begin
            m_rd[63:32] = w;
            m_ld = 0;
        end else if (m_ld == 2) begin
            m_wr[63:32] = w;
            m_ld = 0;
        end else if (op == 0) begin
        end else if (op == 2 || op == 4) begin
            m_rd[31:0] = lo;
            if (op == 2) m_ld = 1;
        end else if (op == 3 || op == 5) begin
            m_wr[31:0] = lo;
            if (op == 3) m_ld = 2;
        end else if (op >= 8 && op < 8 + NU) begin
            e.k   = op - 8;
            e.len = int'(w[26:20]) * 64;
            exp_done = exp_done + 1;
            if (e.len != 0) begin
                e.addr = m_rd + 64'(int'(w[12:6]) * 64);
                rd_q.push_back(e);
                e.addr = m_wr + 64'(int'(w[19:13]) * 64);
                wr_q.push_back(e);
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [31:0] w);
        int t = 0;
        inst_valid = 1'b1;
        inst_data  = w;
        while (!inst_ready && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        if (!inst_ready) begin
            chk("push_timeout", 64'(t), 0);
            inst_valid = 1'b0;
        end else begin
            n_accepted++;
            model(w);
            @(negedge aclk);
            inst_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || !rd_ready || !wr_ready || rd_q.size() > 0 ||
                wr_q.size() > 0) && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        chk("drain_timeout", 64'(t < 3000), 1);
        chk("done_count", 64'(done_count), 64'(exp_done));
        chk("err_illegal", 64'(err_illegal), 64'(exp_err));
    endtask

    // Read mover: ready drops after acceptance, rises after its latency.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rd_pend = 1'b0;
                rd_bcnt = 0;
                rd_ready = !hold;
            end else if (rd_pend) begin
                rd_pend = 1'b0;
                rd_ready = 1'b0;
                rd_bcnt = (rd_lat_sel < 0) ? $urandom_range(0, 4) : rd_lat_sel;
            end else if (rd_bcnt > 0) begin
                rd_bcnt--;
            end else if (rd_valid && rd_ready) begin
                rd_pend = 1'b1;
            end else begin
                rd_ready = !hold;
            end
        end
    end

    initial begin
        wr_ready = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                wr_pend = 1'b0;
                wr_bcnt = 0;
                wr_ready = !hold;
            end else if (wr_pend) begin
                wr_pend = 1'b0;
                wr_ready = 1'b0;
                wr_bcnt = (wr_lat_sel < 0) ? $urandom_range(0, 4) : wr_lat_sel;
            end else if (wr_bcnt > 0) begin
                wr_bcnt--;
            end else if (wr_valid && wr_ready) begin
                wr_pend = 1'b1;
            end else begin
                wr_ready = !hold;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && rd_valid && rd_ready) begin
                chk("rd_cmd_expected", 64'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    chk("rd_src", rd_src, e.addr);
                    chk("rd_len", 64'(rd_len), 64'(e.len));
                    chk("rd_route", 64'(routing_dest), 64'(e.k));
                end
            end
            if (aresetn && wr_valid && wr_ready) begin
                chk("wr_cmd_expected", 64'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    chk("wr_dest", wr_dest, e.addr);
                    chk("wr_len", 64'(rd_len), 64'(e.len));
                    chk("wr_route", 64'(routing_dest), 64'(e.k));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] first_w;
        logic [31:0] d0;
        int          acc0;
        int          t;
        aresetn    = 1'b0;
        inst_valid = 1'b0;
        inst_data  = '0;
        err_clear  = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_inst_ready", 64'(inst_ready), 1);
        chk("rst_head", 64'(head_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rd_valid", 64'(rd_valid), 0);
        chk("rst_wr_valid", 64'(wr_valid), 0);
        chk("rst_done", 64'(done_count), 0);
        chk("rst_err", 64'(err_illegal), 0);
        chk("rst_rd_src", rd_src, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Base loads, then a main command that reveals them.
        push(32'h0004_0004);
        push(32'h0000_0003);
        push(32'h0000_0012);
        drain();
        chk("meta_done_zero", 64'(done_count), 0);
        push(32'h0010_4048);
        drain();
        chk("base_rd_src", rd_src, 64'h0000_0000_0004_0040);
        chk("base_wr_dest", wr_dest, 64'h0000_0012_0000_0080);

        // Read mover finishes 5 cycles after the write mover.
        push(32'h0000_1002);
        push(32'h0000_0000);
        push(32'h0000_2003);
        push(32'h0000_0000);
        drain();
        rd_lat_sel = 5;
        wr_lat_sel = 0;
        d0 = done_count;
        push(32'h00D0_4049);
        repeat (6) @(negedge aclk);
        chk("slow_rd_busy", 64'(busy), 1);
        chk("slow_rd_done_held", 64'(done_count), 64'(d0));
        drain();
        chk("main_rd_src", rd_src, 64'h1040);
        chk("main_wr_dest", wr_dest, 64'h2080);
        chk("main_rd_len", 64'(rd_len), 64'h340);
        chk("main_route", 64'(routing_dest), 1);
        chk("main_done_inc", 64'(done_count), 64'(d0 + 1));
        rd_lat_sel = 0;

        // FIFO full with movers held busy.
        hold = 1'b1;
        repeat (2) @(negedge aclk);
        push(32'h0010_0048);
        repeat (3) @(negedge aclk);
        first_w = '0;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            w[5:0] = 6'(8 + i % NU);
            w[20] = 1'b1;
            if (i == 0) first_w = w;
            push(w);
            if (i == 6) chk("fifo_ready_at_7", 64'(inst_ready), 1);
        end
        chk("fifo_full_at_8", 64'(inst_ready), 0);
        chk("head_peek", 64'(head_data), 64'(first_w));
        acc0 = n_accepted;
        w = 32'h0030_2049;
        fork
            push(w);
            begin
                repeat (4) @(negedge aclk);
                chk("ninth_held", 64'(n_accepted), 64'(acc0));
                hold = 1'b0;
            end
        join
        drain();

        // Illegal opcode, zero-length command, and error clear.
        d0 = exp_done;
        push(32'h0000_000F);
        push(32'h0000_0048);
        drain();
        chk("illegal_set", 64'(err_illegal), 1);
        chk("zero_len_done", 64'(done_count), 64'(d0 + 1));
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        exp_err = 1'b0;
        chk("err_cleared", 64'(err_illegal), 0);
        // Clear and a new illegal opcode in the same cycle: set wins.
        push(32'h0000_0001);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        chk("set_wins", 64'(err_illegal), 1);
        drain();

        // Address wrap.
        push(32'hFFFF_FFC2);
        push(32'hFFFF_FFFF);
        push(32'h0010_0088);
        drain();
        chk("wrap_rd_src", rd_src, 64'h40);

        // Randomised command stream.
        rd_lat_sel = -1;
        wr_lat_sel = -1;
        for (int i = 0; i < 160; i++) begin
            int r;
            r = $urandom_range(0, 99);
            w = $urandom;
            if (r < 45) begin
                w[5:0] = 6'(8 + $urandom_range(0, NU - 1));
                if ($urandom_range(0, 7) == 0) w[26:20] = '0;
            end else if (r < 55) w[5:0] = 6'd0;
            else if (r < 65) w[5:0] = 6'd4;
            else if (r < 75) w[5:0] = 6'd5;
            else if (r < 80) w[5:0] = 6'd2;
            else if (r < 85) w[5:0] = 6'd3;
            else if (r < 90) w[5:0] = ($urandom_range(0, 1) == 0) ? 6'd1 : 6'd6;
            else w[5:0] = 6'($urandom_range(8 + NU, 63));
            push(w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge aclk);
        end
        drain();

        // Reset while a command is outstanding.
        rd_lat_sel = 0;
        wr_lat_sel = 0;
        hold = 1'b1;
        repeat (2) @(negedge aclk);
        push(32'h0010_4049);
        push(32'h0000_0004);
        t = 0;
        while (!rd_valid && t < 20) begin
            @(negedge aclk);
            t++;
        end
        chk("pre_reset_rd_valid", 64'(rd_valid), 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 64'(rd_valid), 0);
        chk("mid_rst_wr_valid", 64'(wr_valid), 0);
        chk("mid_rst_done", 64'(done_count), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_ready", 64'(inst_ready), 1);
        chk("mid_rst_rd_src", rd_src, 0);
        chk("mid_rst_route", 64'(routing_dest), 0);
        chk("mid_rst_err", 64'(err_illegal), 0);
        rd_q.delete();
        wr_q.delete();
        m_rd = '0;
        m_wr = '0;
        m_ld = 0;
        exp_done = '0;
        exp_err = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", 64'(inst_ready), 1);
        chk("post_rst_head", 64'(head_data), 0);
        push(32'h0010_4048);
        drain();
        chk("post_rst_rd_src", rd_src, 64'h40);
        chk("post_rst_wr_dest", wr_dest, 64'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
